// File: rtl/csa_pkg.sv
// Shared definitions for the multi-word sequential adder and its 16-bit slice engine.
package csa_pkg;

    localparam int CSA_SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_t;

    function automatic int csa_idx_w(input int nwords);
        return (nwords <= 1) ? 1 : $clog2(nwords);
    endfunction

endpackage

// File: rtl/csa_mw_seq_csa16.sv
// 16-bit conditional sum adder: every block computes sum/carry for both carry-in
// values, and blocks are merged pairwise over log2(16) levels.
module csa16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] s0, s1;
    logic [15:0] k0, k1;

    // s0/s1: bit sums assuming block carry-in 0/1; k0/k1: block carry-out, kept at the block's first bit
    always_comb begin
        int  lo, up;
        logic t0, t1, nk0, nk1;
        s0 = a ^ b;
        s1 = ~(a ^ b);
        k0 = a & b;
        k1 = a | b;
        lo = 0;
        up = 0;
        t0 = 1'b0;
        t1 = 1'b0;
        nk0 = 1'b0;
        nk1 = 1'b0;
        for (int lvl = 0; lvl < 4; lvl++) begin
            for (int blk = 0; blk < 8; blk++) begin
                if (blk < (8 >> lvl)) begin
                    lo = 2 * blk * (1 << lvl);
                    up = lo + (1 << lvl);
                    for (int j = 0; j < 8; j++) begin
                        if (j < (1 << lvl)) begin
                            t0 = s0[4'(up + j)];
                            t1 = s1[4'(up + j)];
                            s0[4'(up + j)] = k0[4'(lo)] ? t1 : t0;
                            s1[4'(up + j)] = k1[4'(lo)] ? t1 : t0;
                        end
                    end
                    nk0 = k0[4'(lo)] ? k1[4'(up)] : k0[4'(up)];
                    nk1 = k1[4'(lo)] ? k1[4'(up)] : k0[4'(up)];
                    k0[4'(lo)] = nk0;
                    k1[4'(lo)] = nk1;
                end
            end
        end
    end

    assign sum  = cin ? s1 : s0;
    assign cout = cin ? k1[0] : k0[0];

endmodule

// File: rtl/csa_mw_seq.sv
// Multi-word sequential adder: one 16-bit slice per cycle, LSW first, carry chained in a register.
// Optional subtract mode (sub port) is enabled by defining CSA_MW_SUB_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | adding slice idx, one word per cycle
// DONE  | result presented, held until out_ready
module csa_mw_seq
    import csa_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CSA_SLICE_W*NWORDS-1:0] a,
    input  logic [CSA_SLICE_W*NWORDS-1:0] b,
    input  logic                          cin,
`ifdef CSA_MW_SUB_EN
    input  logic                          sub,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CSA_SLICE_W*NWORDS-1:0] sum,
    output logic                          cout,
    output logic                          busy
);
    localparam int IW = csa_idx_w(NWORDS);

    csa_state_t state, next_state;

    logic [NWORDS-1:0][CSA_SLICE_W-1:0] a_reg, b_reg, sum_reg;
    logic [IW-1:0]          idx;
    logic                   carry;
    logic                   cout_reg;
    logic                   last;
    logic                   accept;
    logic [CSA_SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic                   slice_cout;
    logic                   init_carry;

`ifdef CSA_MW_SUB_EN
    logic sub_reg;
    assign slice_b    = sub_reg ? ~b_reg[idx] : b_reg[idx];
    assign init_carry = sub ? 1'b1 : cin;
`else
    assign slice_b    = b_reg[idx];
    assign init_carry = cin;
`endif

    assign slice_a = a_reg[idx];
    assign last    = (idx == IW'(NWORDS - 1));
    assign accept  = in_valid && in_ready;

    csa16 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
`ifdef CSA_MW_SUB_EN
            sub_reg  <= 1'b0;
`endif
        end else begin
            if (state == IDLE && accept) begin
                a_reg <= a;
                b_reg <= b;
                carry <= init_carry;
                idx   <= '0;
`ifdef CSA_MW_SUB_EN
                sub_reg <= sub;
`endif
            end else if (state == RUN) begin
                sum_reg[idx] <= slice_sum;
                carry        <= slice_cout;
                if (last) begin
                    cout_reg <= slice_cout;
                    idx      <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // in_ready held low while reset is asserted so nothing is accepted during reset
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

endmodule

// File: tb/tb_csa_mw_seq.sv
// Self-checking bench for csa_mw_seq (NWORDS=4 plus an NWORDS=1 instance); subtract test under CSA_MW_SUB_EN.
module tb_csa_mw_seq;
    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0, b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout;
    logic          busy;

    logic          in_valid1 = 1'b0;
    logic          in_ready1;
    logic [15:0]   a1 = '0, b1 = '0;
    logic          out_valid1;
    logic          out_ready1 = 1'b0;
    logic [15:0]   sum1;
    logic          cout1;
    logic          busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_mw_seq #(.NWORDS(NW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CSA_MW_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    csa_mw_seq #(.NWORDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(1'b0),
`ifdef CSA_MW_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    // Reference: whole-width arithmetic, carry-out is bit W
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else   return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic s, input int hold);
        logic [W:0] exp;
        int n;
        exp = ref_op(x, y, c, s);
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; cin = c; sub = s;
        chk("in_ready_idle", {64'b0, in_ready}, 65'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        wait_result(n);
        chk("latency", 65'(n), 65'(NW));
        chk("sum", {1'b0, sum}, {1'b0, exp[W-1:0]});
        chk("cout", {64'b0, cout}, {64'b0, exp[W]});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {64'b0, out_valid}, 65'd1);
            chk("hold_in_ready", {64'b0, in_ready}, 65'd0);
            chk("hold_result", {cout, sum}, exp);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_valid", {64'b0, out_valid}, 65'd0);
        chk("drain_in_ready", {64'b0, in_ready}, 65'd1);
        chk("drain_busy", {64'b0, busy}, 65'd0);
    endtask

    initial begin
        logic [W-1:0] p1a, p1b, p2a, p2b;
        logic         p2c;
        logic [W:0]   exp;
        int n;

        #1;
        chk("rst_sum", {1'b0, sum}, '0);
        chk("rst_cout", {64'b0, cout}, '0);
        chk("rst_valid", {64'b0, out_valid}, '0);
        chk("rst_busy", {64'b0, busy}, '0);
        #11 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {64'b0, in_ready}, 65'd1);

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
        chk("ripple_sum_const", {1'b0, sum}, '0);
        do_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 0);
        chk("plain_sum_const", {1'b0, sum}, {1'b0, 64'h0011_0022_0033_0045});
        do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 5);

        // busy rejection: in_valid stays high with changing operands
        p1a = {$urandom, $urandom}; p1b = {$urandom, $urandom};
        p2a = {$urandom, $urandom}; p2b = {$urandom, $urandom}; p2c = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; a = p1a; b = p1b; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NW; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = ~cin;
            @(posedge clk); #1;
        end
        a = p2a; b = p2b; cin = p2c;
        chk("rej_valid", {64'b0, out_valid}, 65'd1);
        chk("rej_in_ready", {64'b0, in_ready}, 65'd0);
        chk("rej_first", {cout, sum}, ref_op(p1a, p1b, 1'b0, 1'b0));
        out_ready = 1'b1;
        chk("rej_in_ready_drain", {64'b0, in_ready}, 65'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rej_idle_ready", {64'b0, in_ready}, 65'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rej_second_busy", {64'b0, busy}, 65'd1);
        wait_result(n);
        chk("rej_latency", 65'(n), 65'(NW));
        chk("rej_second", {cout, sum}, ref_op(p2a, p2b, p2c, 1'b0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset in the middle of RUN (idx==2)
        @(negedge clk);
        in_valid = 1'b1; a = {$urandom, 32'hFFFF_FFFF}; b = {$urandom, 32'h0001_0001}; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {64'b0, out_valid}, '0);
        chk("mid_rst_sum", {1'b0, sum}, '0);
        chk("mid_rst_cout", {64'b0, cout}, '0);
        chk("mid_rst_busy", {64'b0, busy}, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", {64'b0, in_ready}, 65'd1);
        do_op(64'd3, 64'd4, 1'b0, 1'b0, 0);
        chk("after_rst_sum", {1'b0, sum}, 65'd7);

        for (int k = 0; k < 8; k++)
            do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0,
                  int'($urandom_range(0, 3)));

`ifdef CSA_MW_SUB_EN
        do_op(64'd5, 64'd7, 1'b0, 1'b1, 0);
        chk("sub_const", {cout, sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        for (int k = 0; k < 4; k++)
            do_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b1, 1);
`endif

        // single-word instance
        @(negedge clk);
        in_valid1 = 1'b1; a1 = 16'h8000; b1 = 16'h8000;
        chk("w1_in_ready", {64'b0, in_ready1}, 65'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("w1_busy", {64'b0, busy1}, 65'd1);
        chk("w1_valid_early", {64'b0, out_valid1}, 65'd0);
        @(posedge clk); #1;
        chk("w1_valid", {64'b0, out_valid1}, 65'd1);
        chk("w1_sum", {49'b0, sum1}, '0);
        chk("w1_cout", {64'b0, cout1}, 65'd1);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("w1_drain", {64'b0, out_valid1}, 65'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
